door_lock_ctrl: RTL
===================

DOOR_LOCK_CTRL -- requirements
Module: door_lock_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter DIGIT_W, default 4: width of one keypad digit.
REQ-003 Parameter NUM_DIGITS, default 4: number of digits in the code, range 1..16.
REQ-004 Parameter UNLOCK_CYCLES, default 100: unlock pulse length in clocks, minimum 1.
REQ-005 Parameter MAX_TRIES, default 3: consecutive failures that trigger lockout, minimum 1.
REQ-006 Parameter LOCKOUT_CYCLES, default 1000: lockout duration in clocks, minimum 1.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 switch  in  1  1 = lock armed, 0 = bypass (door held open).
REQ-010 pass  in  NUM_DIGITS*DIGIT_W  stored code; digit i is pass[i*DIGIT_W +: DIGIT_W].
REQ-011 key_valid  in  1  single-cycle strobe: key_digit is valid this cycle.
REQ-012 key_digit  in  DIGIT_W  entered digit.
REQ-013 key_clear  in  1  discards the partial entry.
REQ-014 unlock  out  1  registered door-release output.
REQ-015 locked_out  out  1  registered; high during lockout.
REQ-016 digit_cnt  out  clog2(NUM_DIGITS+1)  digits accepted so far.
REQ-017 fail_cnt  out  clog2(MAX_TRIES+1)  consecutive failed attempts.

Function
REQ-018 FSM states SHALL be IDLE, CHECK, OPEN and LOCKOUT; all outputs SHALL be registered.
REQ-019 In IDLE, each key_valid SHALL store key_digit as digit number digit_cnt and increment digit_cnt.
  - The first digit entered is digit 0.
REQ-020 key_clear in IDLE SHALL zero digit_cnt; key_clear with key_valid in the same cycle: clear wins, digit dropped.
REQ-021 When the NUM_DIGITS-th digit is accepted, the FSM SHALL enter CHECK on that edge.
REQ-022 In CHECK, the FSM SHALL compare all entered digits with pass sampled that cycle, then zero digit_cnt.
REQ-023 On match, the FSM SHALL go to OPEN, zero fail_cnt, and raise unlock on the edge leaving CHECK.
  - unlock stays high exactly UNLOCK_CYCLES clocks, then the FSM returns to IDLE.
REQ-024 On mismatch, fail_cnt SHALL increment (saturating at MAX_TRIES).
  - If it reaches MAX_TRIES: go to LOCKOUT.
  - Otherwise: return to IDLE.
REQ-025 In LOCKOUT, locked_out SHALL be high for exactly LOCKOUT_CYCLES clocks.
  - On exit: zero fail_cnt, return to IDLE.
REQ-026 key_valid and key_clear SHALL be ignored in CHECK, OPEN and LOCKOUT.
REQ-027 switch=0 SHALL, from the next edge, force IDLE, unlock=1, locked_out=0, and zero digit_cnt, fail_cnt and all timers.
  - This overrides any state, including OPEN and LOCKOUT.
REQ-028 When switch returns to 1, unlock SHALL drop on the next edge, with the FSM in IDLE.
REQ-029 Timers SHALL be sized to hold max(UNLOCK_CYCLES, LOCKOUT_CYCLES) and SHALL NOT wrap.

Reset
REQ-030 While rst_n=0, asynchronously:
  - state=IDLE;
  - unlock=0, locked_out=0, digit_cnt=0, fail_cnt=0;
  - timers and digit registers cleared.
REQ-031 Reset asserted mid-OPEN or mid-LOCKOUT SHALL abort the operation with no residual state.
REQ-032 The first active edge after rst_n rises SHALL obey REQ-027 if switch=0.

Configuration
REQ-033 Macro DOOR_LOCKOUT_EN SHALL select whether the lockout feature is compiled in.
  - Defined: REQ-024/025 apply as written.
  - Undefined: no LOCKOUT state; a mismatch always returns to IDLE; locked_out and fail_cnt are tied to 0; MAX_TRIES and LOCKOUT_CYCLES are unused.

Verification
REQ-034 Scenario: defaults, switch=1, pass=16'h4321, keys 1,2,3,4 -> CHECK after 4th key; unlock=1 for exactly 100 clocks; fail_cnt=0.
REQ-035 Scenario: keys 1,2,3,5 three times -> fail_cnt goes 1, 2, then LOCKOUT; locked_out=1 for 1000 clocks; keys entered during lockout are ignored; afterwards fail_cnt=0.
REQ-036 Scenario: keys 1,2, then key_clear with key_valid (digit 9), then 1,2,3,4 -> digit_cnt goes 2, 0, then 1..4; unlock asserted.
REQ-037 Scenario: switch=0 at cycle 50 of OPEN -> unlock stays 1, timers cleared; switch=1 -> unlock=0 next edge, FSM in IDLE.
REQ-038 Scenario: rst_n pulsed low at cycle 500 of LOCKOUT -> locked_out=0 immediately, fail_cnt=0; a correct code then unlocks.
REQ-039 Scenario: DOOR_LOCKOUT_EN undefined, 5 wrong codes -> locked_out=0 throughout; a correct 6th code unlocks.

Source files
------------

// File: rtl/door_lock_ctrl.sv
// Keypad door-lock controller: collects NUM_DIGITS keypad digits, compares them with the stored code and
// pulses unlock; `define DOOR_LOCKOUT_EN to add the consecutive-failure lockout.
module door_lock_ctrl #(
    parameter int unsigned DIGIT_W        = 4,
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned UNLOCK_CYCLES  = 100,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1000
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  switch,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]         pass,
    input  logic                                  key_valid,
    input  logic [DIGIT_W-1:0]                    key_digit,
    input  logic                                  key_clear,
    output logic                                  unlock,
    output logic                                  locked_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]       digit_cnt,
    output logic [$clog2(MAX_TRIES+1)-1:0]        fail_cnt
);

    localparam int unsigned CODE_W  = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] LAST_DIGIT  = CNT_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] UNLOCK_LAST = TMR_W'(UNLOCK_CYCLES - 1);

`ifdef DOOR_LOCKOUT_EN
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);
    localparam logic [TMR_W-1:0]  LOCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_TRIES);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OPEN,
        LOCKOUT
    } state_t;

    logic [FAIL_W-1:0] fail_q;
    logic              lock_q;
`else
    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        OPEN
    } state_t;
`endif

    state_t            state;
    logic [TMR_W-1:0]  timer;
    logic [CODE_W-1:0] entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            unlock    <= 1'b0;
            digit_cnt <= '0;
            timer     <= '0;
            entry     <= '0;
`ifdef DOOR_LOCKOUT_EN
            fail_q    <= '0;
            lock_q    <= 1'b0;
`endif
        end else if (!switch) begin
            // Bypass overrides every state and holds the door released.
            state     <= IDLE;
            unlock    <= 1'b1;
            digit_cnt <= '0;
            timer     <= '0;
            entry     <= '0;
`ifdef DOOR_LOCKOUT_EN
            fail_q    <= '0;
            lock_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    unlock <= 1'b0;
                    if (key_clear) begin
                        digit_cnt <= '0;
                    end else if (key_valid) begin
                        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                            if (digit_cnt == CNT_W'(i)) begin
                                entry[i*DIGIT_W +: DIGIT_W] <= key_digit;
                            end
                        end
                        digit_cnt <= digit_cnt + CNT_W'(1);
                        if (digit_cnt == LAST_DIGIT) begin
                            state <= CHECK;
                        end
                    end
                end

                CHECK: begin
                    digit_cnt <= '0;
                    timer     <= '0;
                    if (entry == pass) begin
                        state  <= OPEN;
                        unlock <= 1'b1;
`ifdef DOOR_LOCKOUT_EN
                        fail_q <= '0;
`endif
                    end else begin
`ifdef DOOR_LOCKOUT_EN
                        if (fail_q == FAIL_LAST) begin
                            fail_q <= FAIL_MAX;
                            lock_q <= 1'b1;
                            state  <= LOCKOUT;
                        end else begin
                            fail_q <= fail_q + FAIL_W'(1);
                            state  <= IDLE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end

                OPEN: begin
                    if (timer == UNLOCK_LAST) begin
                        state  <= IDLE;
                        unlock <= 1'b0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end

`ifdef DOOR_LOCKOUT_EN
                LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state  <= IDLE;
                        lock_q <= 1'b0;
                        fail_q <= '0;
                        timer  <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    unlock <= 1'b0;
                    timer  <= '0;
                end
            endcase
        end
    end

`ifdef DOOR_LOCKOUT_EN
    assign locked_out = lock_q;
    assign fail_cnt   = fail_q;
`else
    assign locked_out = 1'b0;
    assign fail_cnt   = '0;
`endif

endmodule
